alu_cmd_parser: RTL and testbench
=================================

// Module: alu_cmd_parser
// PURPOSE
//   Byte-stream front end of the UART ALU. Consumes bytes from the UART receiver, frames
//   and validates ALU command packets, and hands the decoded opcode and operands to the
//   ALU/logic unit over a valid/ready handshake. Malformed, stalled and overrunning frames
//   are reported on a one-cycle error strobe.
// PARAMETERS
//   N               16        operand width; must be a multiple of 8; NB = N/8 bytes per operand
//   SYNC_BYTE       8'hA5     frame start marker
//   TIMEOUT_CYCLES  1000      max idle clocks between bytes inside a frame (>=2)
//   MAX_OPCODE      6         highest legal opcode (0=AND,1=OR,2=XOR,3=NAND,4=NOR,5=XNOR,6=NOT)
// PORTS
//   clk         in   1    system clock, all logic on rising edge
//   rst         in   1    synchronous, active-high reset
//   rx_data     in   8    received byte, valid only when rx_valid=1
//   rx_valid    in   1    one-cycle strobe per received byte; no backpressure
//   cmd_opcode  out  4    decoded opcode
//   cmd_a       out  N    operand A, signed two's complement
//   cmd_b       out  N    operand B, signed two's complement
//   cmd_valid   out  1    command available; held until accepted
//   cmd_ready   in   1    ALU accepts the command when cmd_valid & cmd_ready
//   busy        out  1    1 in any state other than IDLE
//   frame_err   out  1    one-cycle error strobe
//   err_code    out  2    cause, valid with frame_err: 0=overrun 1=checksum 2=bad opcode 3=timeout
// BEHAVIOUR
//   Reset: state=IDLE; cmd_opcode, cmd_a, cmd_b, cmd_valid, busy, frame_err and err_code
//     all 0; byte and timeout counters cleared. Reset mid-frame or mid-handshake discards
//     the frame silently, with no error.
//   Frame: SYNC, OPC, A[NB bytes, MSB first], B[NB bytes, MSB first], CHK.
//     CHK = XOR of OPC and all operand bytes. SYNC is not included.
//   FSM states: IDLE -> OPC -> A -> B -> CHK -> ISSUE -> IDLE.
//   IDLE: rx_valid with rx_data==SYNC_BYTE moves to OPC. Any other byte is ignored, no error.
//   OPC: the byte is legal if bits[7:4]==0 and bits[3:0]<=MAX_OPCODE.
//     Legal: store the opcode and go to A.
//     Illegal: frame_err with err_code=2 on the next cycle, then IDLE.
//   A, B: shift each byte into the operand register MSB-first. After NB bytes, move to the
//     next state. A running XOR accumulates OPC and every operand byte.
//   CHK: on a match, cmd_valid=1 on the next cycle (ISSUE). On a mismatch, frame_err with
//     err_code=1, then IDLE. The cmd_* registers are not updated from a bad frame.
//   Latency: cmd_valid rises exactly 1 clk after the CHK byte strobe.
//   ISSUE: cmd_opcode, cmd_a and cmd_b are stable while cmd_valid=1. On a cycle where
//     cmd_valid & cmd_ready: cmd_valid=0 on the next clk, state returns to IDLE.
//     cmd_ready while not valid has no effect.
//   Overrun: rx_valid during ISSUE drops the byte, frame_err with err_code=0, and the
//     pending command is kept. If that same cycle has cmd_ready, the handshake still completes.
//   Timeout: a counter runs in OPC/A/B/CHK and clears on each rx_valid. When it reaches
//     TIMEOUT_CYCLES: frame_err with err_code=3, state=IDLE. ISSUE has no timeout.
//   Simultaneous byte and timeout in the same cycle: the byte wins and the counter clears.
//   frame_err is a registered single-cycle pulse. err_code holds its last value otherwise.
//   The XOR accumulator and byte counter clear on entering OPC.
// TESTING (N=16, defaults)
//   1. Good frame A5 02 12 34 00 FF DB, cmd_ready=1
//      -> cmd_valid for 1 clk, 1 clk after DB; opcode=2, a=16'h1234, b=16'h00FF; no frame_err.
//   2. Bad checksum A5 02 12 34 00 FF DA
//      -> frame_err with err_code=1; no cmd_valid; next good frame decodes correctly.
//   3. Opcode byte 07 (also test 12)
//      -> frame_err with err_code=2 right after the OPC byte; the following operand bytes
//         are ignored in IDLE.
//   4. A5 02, then silence for 1000 clks
//      -> frame_err with err_code=3 exactly at the timeout; busy=0 afterwards.
//   5. Frame from test 1 with cmd_ready=0 for 10 clks, and one byte sent during the wait
//      -> err_code=0 pulse; cmd_* stable throughout; exactly one transfer when ready rises.
//   6. rst asserted after A5 02 12, then a full good frame sent
//      -> no error; decodes as in test 1; garbage bytes before A5 are ignored.

Source files
------------

// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser: frames SYNC/OPC/A/B/CHK byte packets from the UART into ALU commands
// with a valid/ready handoff and a one-cycle error strobe for bad, stalled or overrun frames.
module alu_cmd_parser #(
  parameter int          N              = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          MAX_OPCODE     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [3:0]   cmd_opcode,
  output logic [N-1:0] cmd_a,
  output logic [N-1:0] cmd_b,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic         busy,
  output logic         frame_err,
  output logic [1:0]   err_code
);
  localparam int NB = N / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_OPC, S_A, S_B, S_CHK, S_ISSUE} state_t;
  state_t        r_state;
  logic [3:0]    r_opc;
  logic [N-1:0]  r_a, r_b;
  logic [7:0]    r_xor;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmo;
  logic          w_opc_ok, w_last, w_in_frame, w_tmo_hit;
  assign w_opc_ok   = (rx_data[7:4] == 4'd0) && (rx_data[3:0] <= 4'(MAX_OPCODE));
  assign w_last     = r_cnt == CW'(NB - 1);
  assign w_in_frame = r_state inside {S_OPC, S_A, S_B, S_CHK};
  // A byte arriving on the expiry cycle wins over the timeout
  assign w_tmo_hit  = w_in_frame && !rx_valid && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign busy       = r_state != S_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_opc      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_xor      <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      cmd_opcode <= '0;
      cmd_a      <= '0;
      cmd_b      <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
    end else begin
      frame_err <= 1'b0;
      r_tmo     <= (w_in_frame && !rx_valid && !w_tmo_hit) ? r_tmo + 1'b1 : '0;
      if (w_tmo_hit) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        r_state   <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
            r_state <= S_OPC;
            r_xor   <= '0;
            r_cnt   <= '0;
          end
          S_OPC: if (rx_valid) begin
            if (w_opc_ok) begin
              r_opc   <= rx_data[3:0];
              r_xor   <= r_xor ^ rx_data;
              r_state <= S_A;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              r_state   <= S_IDLE;
            end
          end
          S_A: if (rx_valid) begin
            r_a     <= N'({r_a, rx_data});
            r_xor   <= r_xor ^ rx_data;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            r_state <= w_last ? S_B : S_A;
          end
          S_B: if (rx_valid) begin
            r_b     <= N'({r_b, rx_data});
            r_xor   <= r_xor ^ rx_data;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            r_state <= w_last ? S_CHK : S_B;
          end
          S_CHK: if (rx_valid) begin
            if (rx_data == r_xor) begin
              cmd_opcode <= r_opc;
              cmd_a      <= r_a;
              cmd_b      <= r_b;
              cmd_valid  <= 1'b1;
              r_state    <= S_ISSUE;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              r_state   <= S_IDLE;
            end
          end
          S_ISSUE: begin
            if (rx_valid) begin
              frame_err <= 1'b1;
              err_code  <= 2'd0;
            end
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_parser.sv
// tb_alu_cmd_parser: directed byte-stream vectors for alu_cmd_parser at N=16 defaults.
module tb_alu_cmd_parser;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_a, cmd_b;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        busy, frame_err;
  logic [1:0]  err_code;
  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;
  alu_cmd_parser dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy), .frame_err(frame_err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst && cmd_valid && cmd_ready) xfers <= xfers + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic send_good1();
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'h00); send(8'hFF); send(8'hDB);
  endtask
  initial begin
    int x0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_a", 32'(cmd_a), 0);
    rst = 1'b0;
    @(negedge clk);
    // 1: good frame, ready high
    send(8'hA5);
    chk("t1_busy", 32'(busy), 1);
    send(8'h02); send(8'h12); send(8'h34); send(8'h00); send(8'hFF);
    chk("t1_prevalid", 32'(cmd_valid), 0);
    send(8'hDB);
    chk("t1_valid", 32'(cmd_valid), 1);
    chk("t1_opc", 32'(cmd_opcode), 2);
    chk("t1_a", 32'(cmd_a), 32'h1234);
    chk("t1_b", 32'(cmd_b), 32'h00FF);
    chk("t1_err", 32'(frame_err), 0);
    @(negedge clk);
    chk("t1_drop", 32'(cmd_valid), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_xfers", 32'(xfers), 1);
    // 2: bad checksum, then a different good frame
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'h00); send(8'hFF); send(8'hDA);
    chk("t2_err", 32'(frame_err), 1);
    chk("t2_code", 32'(err_code), 1);
    chk("t2_novalid", 32'(cmd_valid), 0);
    @(negedge clk);
    chk("t2_pulse", 32'(frame_err), 0);
    chk("t2_hold", 32'(err_code), 1);
    send(8'hA5); send(8'h01); send(8'hAB); send(8'hCD); send(8'h80); send(8'h01); send(8'hE6);
    chk("t2_valid", 32'(cmd_valid), 1);
    chk("t2_opc", 32'(cmd_opcode), 1);
    chk("t2_a", 32'(cmd_a), 32'hABCD);
    chk("t2_b", 32'(cmd_b), 32'h8001);
    @(negedge clk);
    // 3: illegal opcodes 07 and 12; highest legal opcode 06
    send(8'hA5); send(8'h07);
    chk("t3_err07", 32'(frame_err), 1);
    chk("t3_code07", 32'(err_code), 2);
    chk("t3_idle", 32'(busy), 0);
    send(8'h12); send(8'h34); send(8'h00); send(8'hFF); send(8'hDB);
    chk("t3_ignored_valid", 32'(cmd_valid), 0);
    chk("t3_ignored_busy", 32'(busy), 0);
    chk("t3_ignored_err", 32'(frame_err), 0);
    send(8'hA5); send(8'h12);
    chk("t3_err12", 32'(frame_err), 1);
    chk("t3_code12", 32'(err_code), 2);
    send(8'hA5); send(8'h06); send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h06);
    chk("t3_op6_valid", 32'(cmd_valid), 1);
    chk("t3_op6", 32'(cmd_opcode), 6);
    @(negedge clk);
    // 4: timeout after exactly 1000 idle clocks
    send(8'hA5); send(8'h02);
    repeat (999) @(negedge clk);
    chk("t4_early", 32'(frame_err), 0);
    chk("t4_early_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t4_err", 32'(frame_err), 1);
    chk("t4_code", 32'(err_code), 3);
    chk("t4_busy", 32'(busy), 0);
    // byte landing on the expiry cycle wins and restarts the count
    send(8'hA5); send(8'h02);
    repeat (999) @(negedge clk);
    send(8'h12);
    chk("t4b_noerr", 32'(frame_err), 0);
    chk("t4b_busy", 32'(busy), 1);
    send(8'h34); send(8'h00); send(8'hFF); send(8'hDB);
    chk("t4b_valid", 32'(cmd_valid), 1);
    chk("t4b_a", 32'(cmd_a), 32'h1234);
    @(negedge clk);
    // 5: stalled handshake with an overrun byte
    cmd_ready = 1'b0;
    x0 = xfers;
    send_good1();
    chk("t5_valid", 32'(cmd_valid), 1);
    repeat (3) @(negedge clk);
    send(8'h55);
    chk("t5_ovr_err", 32'(frame_err), 1);
    chk("t5_ovr_code", 32'(err_code), 0);
    chk("t5_keep", 32'(cmd_valid), 1);
    repeat (5) @(negedge clk);
    chk("t5_a", 32'(cmd_a), 32'h1234);
    chk("t5_b", 32'(cmd_b), 32'h00FF);
    chk("t5_opc", 32'(cmd_opcode), 2);
    chk("t5_noxfer", 32'(xfers - x0), 0);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("t5_drop", 32'(cmd_valid), 0);
    chk("t5_one", 32'(xfers - x0), 1);
    // overrun on the same cycle as acceptance: both take effect
    send_good1();
    send(8'h77);
    chk("t5b_err", 32'(frame_err), 1);
    chk("t5b_code", 32'(err_code), 0);
    chk("t5b_drop", 32'(cmd_valid), 0);
    chk("t5b_idle", 32'(busy), 0);
    // 6: reset mid-frame, garbage, then a good frame
    send(8'hA5); send(8'h02); send(8'h12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_noerr", 32'(frame_err), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_code", 32'(err_code), 0);
    send(8'h00); send(8'h33);
    chk("t6_garbage", 32'(busy), 0);
    send_good1();
    chk("t6_valid", 32'(cmd_valid), 1);
    chk("t6_a", 32'(cmd_a), 32'h1234);
    chk("t6_b", 32'(cmd_b), 32'h00FF);
    chk("t6_err", 32'(frame_err), 0);
    @(negedge clk);
    chk("t6_drop", 32'(cmd_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
